// File: rtl/iob_uart_frx_engine_if.sv
// Backend-side bundle of the uart_core byte ports and the byte-wide payload memory port.
// master = FRX engine, slave = uart_core / memory side.
interface iob_uart_frx_engine_if #(
    parameter int ADDR_W = 16
);
    logic              uart_tx_ready_i;
    logic [7:0]        uart_tx_data_o;
    logic              uart_tx_wr_o;
    logic              uart_rx_ready_i;
    logic [7:0]        uart_rx_data_i;
    logic              uart_rx_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              mem_we_o;

    modport master (
        input  uart_tx_ready_i,
        input  uart_rx_ready_i,
        input  uart_rx_data_i,
        output uart_tx_data_o,
        output uart_tx_wr_o,
        output uart_rx_rd_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_we_o
    );

    modport slave (
        output uart_tx_ready_i,
        output uart_rx_ready_i,
        output uart_rx_data_i,
        input  uart_tx_data_o,
        input  uart_tx_wr_o,
        input  uart_rx_rd_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_we_o
    );
endinterface

// File: rtl/iob_uart_frx_engine.sv
// FRX file-receive responder: requests a file, reads a 4-byte little-endian size,
// acknowledges it and streams the payload into a byte-wide memory port.
module iob_uart_frx_engine #(
    parameter int ADDR_W   = 16,
    parameter int MAX_SIZE = 65536,
    parameter int TIMEOUT  = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] file_size_o,
    iob_uart_frx_engine_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_FRX,
        GET_SIZE,
        CHECK,
        SEND_ACK,
        GET_DATA,
        SEND_FIN,
        SEND_EOT
    } state_t;

    localparam logic [7:0]  CODE_FRX   = 8'h08;
    localparam logic [7:0]  CODE_ACK   = 8'h06;
    localparam logic [7:0]  CODE_EOT   = 8'h04;
    localparam logic [31:0] MAX_SIZE_W = 32'(MAX_SIZE);
    localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT);

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [31:0]         r_fileSize;
    logic [31:0]         r_byteCnt;
    logic [31:0]         r_timer;
    logic [7:0]          r_txData;
    logic                r_txWr;
    logic                r_txWrD;
    logic                r_rxRd;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [7:0]          r_memWdata;
    logic                r_memWe;

    state_t              w_stateNext;
    logic                w_txFire;
    logic [7:0]          w_txCode;
    logic                w_isRx;
    logic                w_capture;
    logic                w_timedOut;
    logic                w_enterRx;
    logic                w_startOk;

    // The core keeps rx_ready high during our read strobe, so that cycle is skipped.
    assign w_isRx     = (r_state == GET_SIZE) || (r_state == GET_DATA);
    assign w_capture  = w_isRx && bus.uart_rx_ready_i && !r_rxRd;
    assign w_timedOut = (r_timer == TIMEOUT_W);
    assign w_startOk  = (r_state == IDLE) && start_i;
    assign w_enterRx  = ((w_stateNext == GET_SIZE) || (w_stateNext == GET_DATA))
                        && (w_stateNext != r_state);

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:     if (start_i) w_stateNext = SEND_FRX;
            SEND_FRX: if (r_txWr) w_stateNext = GET_SIZE;
            GET_SIZE: begin
                if (w_capture) begin
                    if (r_byteCnt == 32'd3) w_stateNext = CHECK;
                end else if (w_timedOut) begin
                    w_stateNext = SEND_EOT;
                end
            end
            CHECK:    w_stateNext = (r_fileSize > MAX_SIZE_W) ? SEND_EOT : SEND_ACK;
            SEND_ACK: if (r_txWr) w_stateNext = (r_fileSize == 32'd0) ? SEND_FIN : GET_DATA;
            GET_DATA: begin
                if (w_capture) begin
                    if (r_byteCnt == r_fileSize - 32'd1) w_stateNext = SEND_FIN;
                end else if (w_timedOut) begin
                    w_stateNext = SEND_EOT;
                end
            end
            SEND_FIN: if (r_txWr) w_stateNext = IDLE;
            SEND_EOT: if (r_txWr) w_stateNext = IDLE;
            default:  w_stateNext = IDLE;
        endcase
    end

    // The strobe is launched while entering (or waiting in) a send state, so the
    // registered write lands in the send state itself; tx_ready is stale for two cycles.
    always_comb begin
        w_txCode = CODE_ACK;
        w_txFire = 1'b0;
        case (w_stateNext)
            SEND_FRX: w_txCode = CODE_FRX;
            SEND_EOT: w_txCode = CODE_EOT;
            default:  w_txCode = CODE_ACK;
        endcase
        if ((w_stateNext == SEND_FRX) || (w_stateNext == SEND_ACK) ||
            (w_stateNext == SEND_FIN) || (w_stateNext == SEND_EOT)) begin
            w_txFire = bus.uart_tx_ready_i && !r_txWr && !r_txWrD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_fileSize <= '0;
            r_byteCnt  <= '0;
            r_timer    <= '0;
            r_txData   <= '0;
            r_txWr     <= 1'b0;
            r_txWrD    <= 1'b0;
            r_rxRd     <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWe    <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_busy  <= (w_stateNext != IDLE);
            r_done  <= (r_state == SEND_FIN) && r_txWr;
            r_txWr  <= w_txFire;
            r_txWrD <= r_txWr;
            r_rxRd  <= w_capture;
            r_memWe <= w_capture && (r_state == GET_DATA);
            if (w_txFire) begin
                r_txData <= w_txCode;
            end

            if (w_startOk) begin
                r_error    <= 1'b0;
                r_byteCnt  <= '0;
                r_fileSize <= '0;
                r_memAddr  <= '0;
            end else if ((r_state == SEND_EOT) && r_txWr) begin
                r_error <= 1'b1;
            end

            if (w_capture) begin
                if (r_state == GET_SIZE) begin
                    r_fileSize[{r_byteCnt[1:0], 3'b000} +: 8] <= bus.uart_rx_data_i;
                    r_byteCnt <= (r_byteCnt == 32'd3) ? 32'd0 : r_byteCnt + 32'd1;
                end else begin
                    r_memAddr  <= r_byteCnt[ADDR_W-1:0];
                    r_memWdata <= bus.uart_rx_data_i;
                    r_byteCnt  <= r_byteCnt + 32'd1;
                end
            end

            if (w_enterRx || w_capture) begin
                r_timer <= '0;
            end else if (w_isRx) begin
                r_timer <= r_timer + 32'd1;
            end
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign error_o         = r_error;
    assign file_size_o     = r_fileSize;
    assign bus.uart_tx_data_o = r_txData;
    assign bus.uart_tx_wr_o   = r_txWr;
    assign bus.uart_rx_rd_o   = r_rxRd;
    assign bus.mem_addr_o     = r_memAddr;
    assign bus.mem_wdata_o    = r_memWdata;
    assign bus.mem_we_o       = r_memWe;

endmodule
